linear_layer_srl_fifo_v2: RTL and testbench

Parametrised, SRL-based ready/valid stream FIFO. It is the next generation of the single-bit start/handshake shift registers between HLS dataflow processes in the Linear_Layer_i4xi4 pipeline (PE pack stages, quant wrapper).
- Adds occupancy tracking, full/empty handshakes, and almost-full/almost-empty thresholds.
- Adds an optional registered output stage and sticky overflow/underflow error flags.
- Storage stays a shift register (SRL inference, no reset on the data array) with address-selected read.

---
 rtl/linear_layer_srl_fifo_v2.sv | 119 +++++++++++
 tb/tb_linear_layer_srl_fifo_v2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_srl_fifo_v2.sv
// SRL-based ready/valid stream FIFO with occupancy count, threshold flags,
// optional registered output stage and sticky overflow/underflow flags.
module linear_layer_srl_fifo_v2 #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_MARGIN  = 2,
    parameter int unsigned AEMPTY_MARGIN = 2,
    parameter int unsigned OUT_REG       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  if_almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] SrlFull   = CW'(DEPTH);
    localparam logic [CW-1:0] AfullThr  = CW'(DEPTH + OUT_REG - AFULL_MARGIN);
    localparam logic [CW-1:0] AemptyThr = CW'(AEMPTY_MARGIN);

    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic [CW-1:0]         srl_count_q, srl_count_d;
    logic [CW-1:0]         count_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  full_n_q, afull_q, aempty_q;
    logic                  err_of_q, err_uf_q;
    logic                  push, pop, load;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] srl_head;

    // Oldest entry sits at the highest occupied index.
    assign rd_addr  = srl_count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign srl_head = srl_q[rd_addr];

    always_comb begin
        push        = if_write & if_write_ce & full_n_q;
        pop         = if_read & if_read_ce & valid_q;
        load        = 1'b0;
        dout_d      = dout_q;
        valid_d     = valid_q;
        srl_count_d = srl_count_q;
        count_d     = srl_count_q;
        if (OUT_REG != 0) begin
            // Output register refills from the SRL head whenever it is free or being consumed.
            load        = (!valid_q || pop) && (srl_count_q != '0);
            srl_count_d = srl_count_q + CW'(push) - CW'(load);
            if (load) begin
                dout_d  = srl_head;
                valid_d = 1'b1;
            end else if (pop) begin
                valid_d = 1'b0;
            end
            count_d = srl_count_d + CW'(valid_d);
        end else begin
            srl_count_d = srl_count_q + CW'(push) - CW'(pop);
            valid_d     = (srl_count_d != '0);
            count_d     = srl_count_d;
        end
    end

    // Data array is deliberately not reset so it maps onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            srl_q[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            srl_count_q <= '0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            full_n_q    <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            err_of_q    <= 1'b0;
            err_uf_q    <= 1'b0;
        end else begin
            srl_count_q <= srl_count_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            full_n_q    <= (srl_count_d < SrlFull);
            afull_q     <= (count_d >= AfullThr);
            aempty_q    <= (count_d <= AemptyThr);
            if (if_write && if_write_ce && !full_n_q) begin
                err_of_q <= 1'b1;
            end
            if (if_read && if_read_ce && !valid_q) begin
                err_uf_q <= 1'b1;
            end
        end
    end

    assign if_full_n       = full_n_q;
    assign if_almost_full  = afull_q;
    assign if_empty_n      = valid_q;
    assign if_almost_empty = aempty_q;
    assign if_dout         = (OUT_REG != 0) ? dout_q : srl_head;
    assign count           = srl_count_q + ((OUT_REG != 0) ? CW'(valid_q) : CW'(0));
    assign err_overflow    = err_of_q;
    assign err_underflow   = err_uf_q;

endmodule

// File: tb/tb_linear_layer_srl_fifo_v2.sv
// Bench driving one OUT_REG=0 and one OUT_REG=1 instance with shared stimulus,
// each tracked by its own occupancy model and scoreboard queue.
module tb_linear_layer_srl_fifo_v2;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0, wce = 1'b0, rd = 1'b0, rce = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout [2];
    logic          full_n [2];
    logic          afull [2];
    logic          empty_n [2];
    logic          aempty [2];
    logic          err_of [2];
    logic          err_uf [2];
    logic [AW:0]   count [2];

    int            m_srl [2];
    bit            m_ov [2];
    bit            m_of [2];
    bit            m_uf [2];
    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    linear_layer_srl_fifo_v2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .AFULL_MARGIN(2), .AEMPTY_MARGIN(2), .OUT_REG(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .if_write_ce(wce), .if_write(wr), .if_din(din),
        .if_full_n(full_n[0]), .if_almost_full(afull[0]),
        .if_read_ce(rce), .if_read(rd), .if_dout(dout[0]),
        .if_empty_n(empty_n[0]), .if_almost_empty(aempty[0]),
        .count(count[0]), .err_overflow(err_of[0]), .err_underflow(err_uf[0])
    );

    linear_layer_srl_fifo_v2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .AFULL_MARGIN(2), .AEMPTY_MARGIN(2), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .if_write_ce(wce), .if_write(wr), .if_din(din),
        .if_full_n(full_n[1]), .if_almost_full(afull[1]),
        .if_read_ce(rce), .if_read(rd), .if_dout(dout[1]),
        .if_empty_n(empty_n[1]), .if_almost_empty(aempty[1]),
        .count(count[1]), .err_overflow(err_of[1]), .err_underflow(err_uf[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Check outputs against the models mid-cycle, then advance the models across the edge.
    task automatic step();
        bit            exp_full_n, exp_empty_n, p_push, p_pop, p_load;
        int            cnt;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cnt         = m_srl[k] + int'(m_ov[k]);
            exp_full_n  = (m_srl[k] < DEPTH);
            exp_empty_n = (k == 1) ? m_ov[k] : (m_srl[k] > 0);
            chk("count", k, 32'(count[k]), cnt);
            chk("full_n", k, 32'(full_n[k]), 32'(exp_full_n));
            chk("empty_n", k, 32'(empty_n[k]), 32'(exp_empty_n));
            chk("almost_full", k, 32'(afull[k]), 32'(cnt >= int'(DEPTH) + k - 2));
            chk("almost_empty", k, 32'(aempty[k]), 32'(cnt <= 2));
            chk("err_overflow", k, 32'(err_of[k]), 32'(m_of[k]));
            chk("err_underflow", k, 32'(err_uf[k]), 32'(m_uf[k]));
            p_push = wr && wce && exp_full_n;
            p_pop  = rd && rce && exp_empty_n;
            if (p_pop) begin
                if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                    chk("scoreboard_nonempty", k, 32'(0), 32'(1));
                end else begin
                    if (k == 0) exp_d = sb0.pop_front();
                    else exp_d = sb1.pop_front();
                    chk("dout_order", k, 32'(dout[k]), 32'(exp_d));
                end
            end
            if (p_push) begin
                if (k == 0) sb0.push_back(din);
                else sb1.push_back(din);
            end
            if (wr && wce && !exp_full_n) m_of[k] = 1'b1;
            if (rd && rce && !exp_empty_n) m_uf[k] = 1'b1;
            if (k == 0) begin
                m_srl[k] += int'(p_push) - int'(p_pop);
            end else begin
                p_load   = (!m_ov[k] || p_pop) && (m_srl[k] > 0);
                m_srl[k] += int'(p_push) - int'(p_load);
                m_ov[k]  = p_load ? 1'b1 : (p_pop ? 1'b0 : m_ov[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr = 1'b0; wce = 1'b0; rd = 1'b0; rce = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_srl[k] = 0; m_ov[k] = 1'b0; m_of[k] = 1'b0; m_uf[k] = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr = 1'b1; wce = 1'b1; din = base + DW'(i);
            step();
        end
        wr = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_dout_outreg", 1, 32'(dout[1]), 32'h0);
        step();

        // Fill with 0x10..0x1F, watching the almost_full edge at count 14.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wce = 1'b1; din = DW'(8'h10 + i);
            step();
            if (i == 12) chk("afull_before_14", 0, 32'(afull[0]), 32'(0));
            if (i == 13) chk("afull_at_14", 0, 32'(afull[0]), 32'(1));
        end
        chk("full_after_16", 0, 32'(full_n[0]), 32'(0));

        // dut0 full: 0xAA dropped; dut1 takes it as its 17th entry.
        din = 8'hAA;
        step();
        chk("overflow_count", 0, 32'(count[0]), 32'd16);
        chk("overflow_set", 0, 32'(err_of[0]), 32'(1));
        chk("no_overflow_cap17", 1, 32'(err_of[1]), 32'(0));
        chk("count_cap17", 1, 32'(count[1]), 32'd17);
        din = 8'hAB;
        step();
        chk("overflow_set", 1, 32'(err_of[1]), 32'(1));
        chk("count_still17", 1, 32'(count[1]), 32'd17);
        wr = 1'b0;

        // Drain 16, then refill 5; overflow must stay sticky.
        rd = 1'b1; rce = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rd = 1'b0;
        chk("drained", 0, 32'(count[0]), 32'd0);
        chk("aempty_drained", 0, 32'(aempty[0]), 32'(1));
        push_n(5, 8'h30);
        chk("overflow_sticky", 0, 32'(err_of[0]), 32'(1));
        chk("refill_count", 0, 32'(count[0]), 32'd5);

        // Sustained push+pop at count 5.
        wr = 1'b1; wce = 1'b1; rd = 1'b1; rce = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = DW'(8'h40 + i);
            step();
        end
        wr = 1'b0; rd = 1'b0;
        chk("steady_count", 0, 32'(count[0]), 32'd5);
        chk("steady_no_underflow", 0, 32'(err_uf[0]), 32'(0));

        // Latency: single push of 0x5C at edge t.
        do_reset();
        wr = 1'b1; wce = 1'b1; din = 8'h5C;
        step();
        wr = 1'b0;
        chk("fwft_latency1", 0, 32'(empty_n[0]), 32'(1));
        chk("fwft_dout", 0, 32'(dout[0]), 32'h5C);
        chk("outreg_not_yet", 1, 32'(empty_n[1]), 32'(0));
        step();
        chk("outreg_latency2", 1, 32'(empty_n[1]), 32'(1));
        chk("outreg_dout", 1, 32'(dout[1]), 32'h5C);
        push_n(15, 8'h60);
        chk("outreg_not_full16", 1, 32'(full_n[1]), 32'(1));
        push_n(1, 8'h70);
        chk("outreg_count17", 1, 32'(count[1]), 32'd17);
        chk("outreg_full17", 1, 32'(full_n[1]), 32'(0));

        // Underflow on empty, then reset in the middle of a stream.
        do_reset();
        rd = 1'b1; rce = 1'b1;
        step();
        rd = 1'b0;
        chk("underflow_set", 0, 32'(err_uf[0]), 32'(1));
        chk("underflow_count", 0, 32'(count[0]), 32'd0);
        chk("underflow_set", 1, 32'(err_uf[1]), 32'(1));
        push_n(9, 8'h80);
        chk("mid_count9", 0, 32'(count[0]), 32'd9);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_count", k, 32'(count[k]), 32'd0);
            chk("rst_empty_n", k, 32'(empty_n[k]), 32'(0));
            chk("rst_full_n", k, 32'(full_n[k]), 32'(1));
            chk("rst_err_of", k, 32'(err_of[k]), 32'(0));
            chk("rst_err_uf", k, 32'(err_uf[k]), 32'(0));
        end
        step();

        // Random traffic, alternating write-heavy and read-heavy phases.
        for (int c = 0; c < 10000; c++) begin
            int wp;
            wp  = ((c / 500) % 2 == 0) ? 70 : 30;
            wr  = ($urandom_range(0, 99) < wp);
            rd  = ($urandom_range(0, 99) < (100 - wp));
            wce = ($urandom_range(0, 3) != 0);
            rce = ($urandom_range(0, 3) != 0);
            din = DW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
